// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED driver. A shared prescaler (tick source)
// and a shared PWM counter feed CHANNELS independent mode engines, each set
// through a one-cycle write port. Every LED output is registered.
module led_pattern_gen #(
    parameter int CHANNELS  = 3,
    parameter int CH_BITS   = 2,
    parameter int CNT_WIDTH = 24,
    parameter int PWM_BITS  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [CH_BITS-1:0]  wr_ch,
    input  logic [2:0]          wr_mode,
    input  logic [PWM_BITS-1:0] wr_arg,
    output logic                tick,
    output logic [CHANNELS-1:0] led
);

    typedef enum logic [2:0] {
        MODE_OFF     = 3'd0,
        MODE_ON      = 3'd1,
        MODE_BLINK   = 3'd2,
        MODE_PWM     = 3'd3,
        MODE_BREATHE = 3'd4,
        MODE_DOUBLE  = 3'd5
    } mode_e;

    // Breathe direction is the state of a two-state FSM per channel.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // The mode is kept as raw bits so reserved codes 6/7 are stored as
    // written and simply decode to OFF.
    typedef struct packed {
        logic [2:0]          mode;
        logic [PWM_BITS-1:0] arg;
        logic [PWM_BITS-1:0] blink_cnt;
        logic                blink;
        logic [PWM_BITS-1:0] level;
        dir_e                dir;
    } chan_t;

    localparam chan_t CHAN_RESET = '{
        mode:      MODE_OFF,
        arg:       '0,
        blink_cnt: '0,
        blink:     1'b0,
        level:     '0,
        dir:       DIR_UP
    };

    localparam logic [PWM_BITS-1:0]  PWM_ONE = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0]  PWM_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] prescaler_q, prescaler_d;
    logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [CHANNELS-1:0]  led_q, led_d;
    logic [CHANNELS-1:0]  wr_sel;
    chan_t                ch_q [CHANNELS];
    chan_t                ch_d [CHANNELS];

    assign tick = (prescaler_q == '1);
    assign led  = led_q;

    // Free-running shared counters; both wrap naturally.
    always_comb begin
        prescaler_d = prescaler_q + CNT_ONE;
        pwm_cnt_d   = pwm_cnt_q + PWM_ONE;
    end

    // Channel select for the write port; out-of-range wr_ch matches no channel
    // and the write is dropped.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_sel[i] = wr_en && (wr_ch == CH_BITS'(i));
        end
    end

    // Per-channel next state: a write reloads the channel and masks any tick
    // that lands on the same edge; otherwise a tick advances BLINK/BREATHE.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            // NOTE: every combinational output gets a default first so no path
            // leaves it unassigned, which would otherwise infer a latch.
            ch_d[i] = ch_q[i];
            if (wr_sel[i]) begin
                ch_d[i]      = CHAN_RESET;
                ch_d[i].mode = wr_mode;
                ch_d[i].arg  = wr_arg;
            end else if (tick) begin
                case (ch_q[i].mode)
                    MODE_BLINK: begin
                        if (ch_q[i].blink_cnt == ch_q[i].arg) begin
                            ch_d[i].blink_cnt = '0;
                            ch_d[i].blink     = ~ch_q[i].blink;
                        end else begin
                            ch_d[i].blink_cnt = ch_q[i].blink_cnt + PWM_ONE;
                        end
                    end
                    MODE_BREATHE: begin
                        case (ch_q[i].dir)
                            DIR_UP: begin
                                if (ch_q[i].level != PWM_MAX) begin
                                    ch_d[i].level = ch_q[i].level + PWM_ONE;
                                end
                                // Turn around on the tick that reaches the top.
                                if (ch_q[i].level >= PWM_MAX - PWM_ONE) begin
                                    ch_d[i].dir = DIR_DOWN;
                                end
                            end
                            default: begin
                                if (ch_q[i].level != '0) begin
                                    ch_d[i].level = ch_q[i].level - PWM_ONE;
                                end
                                // Turn around on the tick that reaches zero.
                                if (ch_q[i].level <= PWM_ONE) begin
                                    ch_d[i].dir = DIR_UP;
                                end
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    // LED drive decode from the registered channel state and shared counters.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (ch_q[i].mode)
                MODE_ON:      led_d[i] = 1'b1;
                MODE_BLINK:   led_d[i] = ch_q[i].blink;
                MODE_PWM:     led_d[i] = (pwm_cnt_q < ch_q[i].arg);
                MODE_BREATHE: led_d[i] = (pwm_cnt_q < ch_q[i].level);
                MODE_DOUBLE:  led_d[i] = prescaler_q[CNT_WIDTH-1] & prescaler_q[CNT_WIDTH-2];
                default:      led_d[i] = 1'b0;
            endcase
        end
    end

    // State registers with synchronous reset; reset wins over any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignment so every flop
            // samples pre-edge values regardless of statement order.
            prescaler_q <= '0;
            pwm_cnt_q   <= '0;
            led_q       <= '0;
            // NOTE: the per-channel array is a handful of control flops, not a
            // RAM, so it is reset explicitly; no channel state survives reset.
            for (int i = 0; i < CHANNELS; i++) begin
                ch_q[i] <= CHAN_RESET;
            end
        end else begin
            prescaler_q <= prescaler_d;
            pwm_cnt_q   <= pwm_cnt_d;
            led_q       <= led_d;
            for (int i = 0; i < CHANNELS; i++) begin
                ch_q[i] <= ch_d[i];
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed stimulus with a scoreboard. The stimulus pushes
// expected led/tick values keyed by sample cycle; a monitor pops and compares
// them on each falling edge.
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [2:0] wr_mode;
    logic [3:0] wr_arg;
    logic       tick;
    logic [2:0] led;

    typedef struct {
        int         at;
        logic [2:0] mask;
        logic [2:0] led;
        logic       tick;
        int         phase;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int cyc = 0;      // rising edges since start, never reset
    int n   = 0;      // rising edges since last reset edge (prescaler/pwm value)
    int checks   = 0;
    int failures = 0;

    led_pattern_gen #(
        .CHANNELS (3),
        .CH_BITS  (2),
        .CNT_WIDTH(4),
        .PWM_BITS (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_mode(wr_mode),
        .wr_arg (wr_arg),
        .tick   (tick),
        .led    (led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    function automatic string phase_name(input int p);
        case (p)
            0: return "reset_state";
            1: return "reset_release";
            2: return "pwm_arg4";
            3: return "pwm_arg0";
            4: return "blink_arg2";
            5: return "blink_rewrite";
            6: return "blink_arg0_tick";
            7: return "breathe";
            8: return "double";
            9: return "bad_channel";
            10: return "reserved_mode";
            11: return "midop_reset";
            default: return "unknown";
        endcase
    endfunction

    // Number of tick edges among edges whose pre-edge count lies in [lo, hi].
    function automatic int ticks_in(input int lo, input int hi);
        int c = 0;
        for (int x = lo; x <= hi; x++) begin
            if (x % 16 == 15) c++;
        end
        return c;
    endfunction

    // Breathe level after j ticks: 0..15 up, 15..0 down, period 30.
    function automatic int tri_level(input int j);
        int r = j % 30;
        return (r <= 15) ? r : 30 - r;
    endfunction

    function automatic logic tick_at(input int m);
        return (m % 16 == 15);
    endfunction

    function automatic logic dbl_at(input int m);
        return ((m - 1) % 16) >= 12;
    endfunction

    task automatic push(input int d, input logic [2:0] mask, input logic [2:0] led_v,
                        input logic tick_v, input int phase);
        exp_t e;
        int   k;
        e.at    = cyc + d;
        e.mask  = mask;
        e.led   = led_v;
        e.tick  = tick_v;
        e.phase = phase;
        k = sb.size();
        while (k > 0 && sb[k-1].at > e.at) k--;
        sb.insert(k, e);
    endtask

    // Called at a falling edge; the write is taken on the next rising edge.
    task automatic do_write(input logic [1:0] ch, input logic [2:0] mode, input logic [3:0] arg);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_mode = mode;
        wr_arg  = arg;
        @(negedge clk);
        wr_en   = 1'b0;
        wr_ch   = '0;
        wr_mode = '0;
        wr_arg  = '0;
    endtask

    // Monitor: compare every expectation scheduled for this sample cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.at != cyc) begin
                failures++;
                $display("FAIL %s stale entry at=%0d cyc=%0d", phase_name(mon_e.phase), mon_e.at, cyc);
            end else if ((((led ^ mon_e.led) & mon_e.mask) != 3'b000) || (tick !== mon_e.tick)) begin
                failures++;
                $display("FAIL %s cyc=%0d n=%0d led=%b exp_led=%b mask=%b tick=%b exp_tick=%b",
                         phase_name(mon_e.phase), cyc, n, led, mon_e.led, mon_e.mask, tick, mon_e.tick);
            end
        end
    end

    initial begin
        int         base;
        int         m;
        int         t;
        int         guard;
        logic [2:0] lv;

        // Reset held for three edges with a write attempt that must be ignored.
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_ch   = 2'd0;
        wr_mode = 3'd1;
        wr_arg  = 4'd0;
        @(negedge clk);
        @(negedge clk);
        push(1, 3'b111, 3'b000, 1'b0, 0);
        @(negedge clk);
        rst   = 1'b0;
        wr_en = 1'b0;
        for (int d = 1; d <= 40; d++) push(d, 3'b111, 3'b000, tick_at(n + d), 1);
        repeat (40) @(negedge clk);

        // PWM duty 4/16 aligned to pwm_cnt 0..3, then duty 0.
        do_write(2'd0, 3'd3, 4'd4);
        for (int d = 1; d <= 32; d++) begin
            m  = n + d;
            lv = {2'b00, ((m - 1) % 16) < 4};
            push(d, 3'b001, lv, tick_at(m), 2);
        end
        repeat (32) @(negedge clk);
        do_write(2'd0, 3'd3, 4'd0);
        for (int d = 1; d <= 16; d++) push(d, 3'b001, 3'b000, tick_at(n + d), 3);
        repeat (16) @(negedge clk);

        // BLINK arg 2, written on a tick edge, then rewritten mid-period.
        while (n % 16 != 15) @(negedge clk);
        base = n;
        do_write(2'd1, 3'd2, 4'd2);
        for (int d = 1; d <= 68; d++) begin
            m  = n + d;
            t  = ticks_in(base + 1, m - 2);
            lv = {1'b0, ((t / 3) % 2) == 1, 1'b0};
            push(d, 3'b010, lv, tick_at(m), 4);
        end
        repeat (69) @(negedge clk);
        base = n;
        do_write(2'd1, 3'd2, 4'd2);
        for (int d = 1; d <= 100; d++) begin
            m  = n + d;
            t  = ticks_in(base + 1, m - 2);
            lv = {1'b0, ((t / 3) % 2) == 1, 1'b0};
            push(d, 3'b010, lv, tick_at(m), 5);
        end
        repeat (100) @(negedge clk);

        // BLINK arg 0 written on a tick edge: that tick must not toggle.
        while (n % 16 != 15) @(negedge clk);
        base = n;
        do_write(2'd1, 3'd2, 4'd0);
        for (int d = 1; d <= 40; d++) begin
            m  = n + d;
            t  = ticks_in(base + 1, m - 2);
            lv = {1'b0, (t % 2) == 1, 1'b0};
            push(d, 3'b010, lv, tick_at(m), 6);
        end
        repeat (40) @(negedge clk);

        // BREATHE: full up/down triangle, no wrap at 15 or 0.
        while (n % 16 != 0) @(negedge clk);
        base = n;
        do_write(2'd2, 3'd4, 4'd0);
        for (int d = 1; d <= 500; d++) begin
            m  = n + d;
            t  = ticks_in(base + 1, m - 2);
            lv = {((m - 1) % 16) < tri_level(t), 2'b00};
            push(d, 3'b100, lv, tick_at(m), 7);
        end
        repeat (500) @(negedge clk);

        // DOUBLE on ch0: high for the top quarter of each tick period.
        do_write(2'd0, 3'd5, 4'd0);
        for (int d = 1; d <= 40; d++) begin
            m = n + d;
            push(d, 3'b001, {2'b00, dbl_at(m)}, tick_at(m), 8);
        end
        repeat (40) @(negedge clk);

        // Out-of-range channel write leaves every channel unchanged.
        do_write(2'd1, 3'd1, 4'd0);
        do_write(2'd2, 3'd0, 4'd0);
        do_write(2'd3, 3'd1, 4'd0);
        for (int d = 1; d <= 32; d++) begin
            m = n + d;
            push(d, 3'b111, {1'b0, 1'b1, dbl_at(m)}, tick_at(m), 9);
        end
        repeat (32) @(negedge clk);

        // Reserved mode behaves as OFF.
        do_write(2'd1, 3'd6, 4'd0);
        for (int d = 1; d <= 20; d++) begin
            m = n + d;
            push(d, 3'b111, {2'b00, dbl_at(m)}, tick_at(m), 10);
        end
        repeat (20) @(negedge clk);

        // Mid-operation reset clears everything, including a write during it.
        do_write(2'd1, 3'd1, 4'd0);
        do_write(2'd2, 3'd3, 4'd15);
        repeat (2) @(negedge clk);
        push(1, 3'b111, 3'b000, 1'b0, 11);
        for (int k = 1; k <= 34; k++) push(1 + k, 3'b111, 3'b000, tick_at(k), 11);
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_ch   = 2'd2;
        wr_mode = 3'd1;
        @(negedge clk);
        rst   = 1'b0;
        wr_en = 1'b0;
        wr_ch = '0;
        wr_mode = '0;
        repeat (34) @(negedge clk);

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Multi-channel LED driver; parametrised successor to the fixed free-running-counter blinkers.
- One shared prescaler and one shared PWM counter drive CHANNELS independent LED outputs.
- Each channel has its own runtime-written mode: OFF, ON, BLINK, PWM, BREATHE or DOUBLE.
- Sits between the board clock and the LED pins; a simple one-cycle write port configures the channels.

Parameters:
CHANNELS, 3, number of LED channels (1..8)
CH_BITS, 2, width of wr_ch; must satisfy 2^CH_BITS >= CHANNELS
CNT_WIDTH, 24, prescaler width; tick period = 2^CNT_WIDTH clocks (>= 3)
PWM_BITS, 8, width of the PWM counter, duty values and breathe level

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  write strobe; one write per high cycle
wr_ch  in  CH_BITS  target channel
wr_mode  in  3  0 OFF, 1 ON, 2 BLINK, 3 PWM, 4 BREATHE, 5 DOUBLE, 6/7 reserved (behave as OFF)
wr_arg  in  PWM_BITS  mode argument (BLINK rate or PWM duty)
tick  out  1  high for one cycle when prescaler == all-ones
led  out  CHANNELS  registered LED drive; led[i] belongs to channel i

Behaviour:
- Reset (rst high at an edge):
  - prescaler = 0, pwm_cnt = 0.
  - All channels: mode OFF, arg 0, blink_cnt 0, blink_q 0, level 0, dir UP.
  - led = 0; tick = 0 (follows from prescaler = 0).
  - Writes are ignored while rst is high. Reset mid-operation aborts everything; no state survives.
- Prescaler: CNT_WIDTH-bit counter, +1 every clock, wraps max -> 0.
  - tick = (prescaler == 2^CNT_WIDTH-1), combinational from the register.
  - First tick occurs 2^CNT_WIDTH-1 clocks after reset release; then every 2^CNT_WIDTH clocks.
- pwm_cnt: PWM_BITS-bit counter, +1 every clock, wraps. Not gated by tick.
- Write: at an edge with wr_en=1, rst=0 and wr_ch < CHANNELS:
  - Channel mode and arg are loaded.
  - blink_cnt, blink_q, level and dir are cleared (dir = UP).
  - wr_ch >= CHANNELS: write is silently dropped.
  - A write and a tick hitting the same channel in the same cycle: the write wins and the tick is ignored for that channel.
- Per-channel tick actions (on edges where tick=1 and the channel is not being written):
  - BLINK: if blink_cnt == arg, then blink_cnt = 0 and blink_q toggles; else blink_cnt + 1. Toggle every arg+1 ticks; arg=0 toggles on every tick.
  - BREATHE, 2-state FSM:
    - UP: level + 1; when level reaches 2^PWM_BITS-1, go to DOWN on that same tick.
    - DOWN: level - 1; when level reaches 0, go to UP on that same tick.
    - No wrap or overflow is permitted.
  - Other modes: tick has no effect; blink/breathe state holds.
- LED next-state, registered, so 1 clock latency from the state it is computed from:
  - OFF / reserved: 0
  - ON: 1
  - BLINK: blink_q
  - PWM: pwm_cnt < arg, unsigned. arg=0 gives constant 0; max arg gives (2^PWM_BITS-1)/2^PWM_BITS duty.
  - BREATHE: pwm_cnt < level.
  - DOUBLE: prescaler[CNT_WIDTH-1] & prescaler[CNT_WIDTH-2], i.e. high 1/4 of each tick period.
- A mode change is visible on led on the 2nd edge after the write edge (register load, then output register).
- Channels are fully independent; no arbitration is needed.

Test Plan:
- Use CNT_WIDTH=4, PWM_BITS=4, CHANNELS=3 throughout.
- Reset: rst high for 3 clocks -> led=000, tick=0. After release, tick is high on exactly cycle 15, then every 16 clocks; no writes are accepted during rst.
- PWM: write ch0 mode 3 arg 4 -> after 2 clocks, led[0] is high for exactly 4 of every 16 consecutive clocks, aligned to pwm_cnt 0..3 (+1 latency). Repeat with arg 0 -> led[0] stays 0.
- BLINK: write ch1 mode 2 arg 2 -> led[1] toggles on every 3rd tick, i.e. a 48-clock half period and 96-clock full period. Rewrite ch1 mid-period -> led[1] returns to 0 and the count restarts.
- BREATHE: write ch2 mode 4 -> level rises 0..15 over 15 ticks, then falls 15..0 over 15 ticks. Per 16-clock PWM window, the led[2] high count equals level, with no wrap at 15 or 0.
- DOUBLE plus edge cases:
  - ch0 mode 5 -> led[0] high while prescaler is 12..15 (+1 clock).
  - wr_ch=3 -> all channels unchanged.
  - wr_mode 6 -> led off.
  - Write coincident with a tick on a BLINK channel -> no toggle that cycle.
